// File: rtl/snake_body_ctrl.sv
// Snake body controller: circular cell buffer, move/grow, self-collision scan,
// and erase-tail / draw-head plot requests over a waitrequest handshake.
module snake_body_ctrl #(
   parameter int         MAX_LEN      = 32,
   parameter logic [3:0] INIT_X       = 4'd8,
   parameter logic [3:0] INIT_Y       = 4'd8,
   parameter logic [2:0] SNAKE_COLOUR = 3'b010,
   parameter logic [2:0] BG_COLOUR    = 3'b000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     step,
   input  logic [1:0]               dir,
   input  logic                     grow,
   input  logic                     waitrequest,
   output logic                     game_plot,
   output logic [3:0]               game_x,
   output logic [3:0]               game_y,
   output logic [2:0]               game_colour,
   output logic                     busy,
   output logic                     collide,
   output logic [$clog2(MAX_LEN):0] len
);

   localparam int PW = $clog2(MAX_LEN);
   localparam int LW = PW + 1;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_CHECK,
      S_ERASE,
      S_DRAW,
      S_DEAD
   } state_t;

   state_t state, state_n;

   // each entry is {x, y}
   logic [7:0]    cells [MAX_LEN];
   logic [PW-1:0] head_ptr, tail_ptr, scan_ptr;
   logic [LW-1:0] scan_cnt;
   logic [3:0]    nx, ny;
   logic          grow_q;

   logic          accept, hit, grow_eff;
   logic [3:0]    hx, hy, step_x, step_y;
   logic          plot_n;
   logic [3:0]    x_n, y_n;
   logic [2:0]    col_n;

   assign accept   = game_plot & ~waitrequest;
   assign {hx, hy} = cells[head_ptr];
   assign grow_eff = grow & (len < LW'(MAX_LEN));
   assign hit      = (scan_cnt != '0) &&
                     (cells[scan_ptr] == {nx, ny});

   always_comb begin
      step_x = hx;
      step_y = hy;
      unique case (dir)
         2'b00: step_x = hx + 4'd1;
         2'b01: step_y = hy + 4'd1;
         2'b10: step_x = hx - 4'd1;
         2'b11: step_y = hy - 4'd1;
      endcase
   end

   always_comb begin
      state_n = state;
      unique case (state)
         S_INIT:  if (accept) state_n = S_IDLE;
         S_IDLE:  if (step) state_n = S_CHECK;
         S_CHECK: begin
            if (hit)
               state_n = S_DEAD;
            else if (scan_cnt <= LW'(1))
               state_n = grow_q ? S_DRAW : S_ERASE;
         end
         S_ERASE: if (accept) state_n = S_DRAW;
         S_DRAW:  if (accept) state_n = S_IDLE;
         S_DEAD:  state_n = S_DEAD;
         default: state_n = S_INIT;
      endcase
   end

   // request fields derive from the state being entered, so they stay put
   // for as long as that state waits on waitrequest
   always_comb begin
      plot_n = 1'b0;
      x_n    = game_x;
      y_n    = game_y;
      col_n  = game_colour;
      unique case (state_n)
         S_INIT: begin
            plot_n = 1'b1;
            x_n    = INIT_X;
            y_n    = INIT_Y;
            col_n  = SNAKE_COLOUR;
         end
         S_ERASE: begin
            plot_n     = 1'b1;
            {x_n, y_n} = cells[tail_ptr];
            col_n      = BG_COLOUR;
         end
         S_DRAW: begin
            plot_n = 1'b1;
            x_n    = nx;
            y_n    = ny;
            col_n  = SNAKE_COLOUR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_INIT;
         head_ptr    <= '0;
         tail_ptr    <= '0;
         scan_ptr    <= '0;
         scan_cnt    <= '0;
         nx          <= INIT_X;
         ny          <= INIT_Y;
         grow_q      <= 1'b0;
         len         <= LW'(1);
         collide     <= 1'b0;
         busy        <= 1'b1;
         game_plot   <= 1'b0;
         game_x      <= '0;
         game_y      <= '0;
         game_colour <= '0;
         cells[0]    <= {INIT_X, INIT_Y};
      end else begin
         state       <= state_n;
         game_plot   <= plot_n;
         game_x      <= x_n;
         game_y      <= y_n;
         game_colour <= col_n;
         busy        <= !(state_n == S_IDLE ||
                          state_n == S_DEAD);
         if (state_n == S_DEAD)
            collide <= 1'b1;
         if (state == S_IDLE && step) begin
            nx     <= step_x;
            ny     <= step_y;
            grow_q <= grow_eff;
            // a non-growing move skips the tail, which vacates first
            if (grow_eff) begin
               scan_ptr <= tail_ptr;
               scan_cnt <= len;
            end else begin
               scan_ptr <= tail_ptr + PW'(1);
               scan_cnt <= len - LW'(1);
            end
         end
         if (state == S_CHECK && !hit &&
             scan_cnt > LW'(1)) begin
            scan_ptr <= scan_ptr + PW'(1);
            scan_cnt <= scan_cnt - LW'(1);
         end
         if (state == S_ERASE && accept)
            tail_ptr <= tail_ptr + PW'(1);
         if (state == S_DRAW && accept) begin
            head_ptr                 <= head_ptr + PW'(1);
            cells[head_ptr + PW'(1)] <= {nx, ny};
            len                      <= len + LW'(grow_q);
         end
      end
   end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Scoreboard bench for snake_body_ctrl: queue-based snake model feeds
// expected plots; a plotter stub/monitor pops and compares on accept.
module tb_snake_body_ctrl;

   localparam int MAXL = 8;
   localparam int LW   = $clog2(MAXL) + 1;
   localparam logic [2:0] SNAKE = 3'b010;
   localparam logic [2:0] BG    = 3'b000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          step = 1'b0;
   logic [1:0]    dir = 2'b00;
   logic          grow = 1'b0;
   logic          waitrequest = 1'b0;
   logic          game_plot;
   logic [3:0]    game_x, game_y;
   logic [2:0]    game_colour;
   logic          busy, collide;
   logic [LW-1:0] len;

   always #5 clk = ~clk;

   snake_body_ctrl #(
      .MAX_LEN(MAXL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .step(step),
      .dir(dir),
      .grow(grow),
      .waitrequest(waitrequest),
      .game_plot(game_plot),
      .game_x(game_x),
      .game_y(game_y),
      .game_colour(game_colour),
      .busy(busy),
      .collide(collide),
      .len(len)
   );

   int          tests = 0;
   int          fails = 0;
   logic [7:0]  body[$];
   logic [10:0] exp_q[$];
   bit          dead = 1'b0;
   int          wr_hold = 0;
   bit          wr_force = 1'b0;
   bit          wr_rand = 1'b0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   initial begin : plotter
      int          hold_cnt;
      bit          acc, pend, prst;
      logic [10:0] held;
      hold_cnt = 0;
      pend = 1'b0;
      prst = 1'b1;
      held = '0;
      forever begin
         @(negedge clk);
         if (pend && !prst && !rst)
            check("hold_stable",
                  {game_plot, game_x, game_y, game_colour},
                  {1'b1, held});
         acc  = game_plot && !waitrequest && !rst;
         pend = game_plot && waitrequest;
         held = {game_x, game_y, game_colour};
         prst = rst;
         if (acc) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_plot: got (%0d,%0d,%0d), want none",
                        game_x, game_y, game_colour);
            end else begin
               check("plot_cell", {game_x, game_y, game_colour},
                     exp_q.pop_front());
            end
         end
         @(posedge clk);
         #1;
         if (acc) hold_cnt = wr_hold;
         else if (hold_cnt > 0) hold_cnt--;
         waitrequest = wr_force || (hold_cnt > 0) ||
                       (wr_rand && $urandom_range(0, 2) == 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
      check("idle_reached", busy, 0);
      check("len", len, body.size());
      check("collide", collide, dead);
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic do_reset(input bit exact);
      rst = 1'b1;
      exp_q.delete();
      wr_force = 1'b0;
      tick();
      check("rst_plot", game_plot, 0);
      check("rst_xyc", {game_x, game_y, game_colour}, 0);
      check("rst_busy", busy, 1);
      check("rst_collide", collide, 0);
      check("rst_len", len, 1);
      tick();
      rst = 1'b0;
      body.delete();
      body.push_back(8'h88);
      dead = 1'b0;
      exp_q.push_back({4'd8, 4'd8, SNAKE});
      tick();
      check("init_plot", game_plot, 1);
      check("init_cell", {game_x, game_y, game_colour},
            {4'd8, 4'd8, SNAKE});
      if (exact) begin
         tick();
         check("init_done_busy", busy, 0);
      end
      wait_idle();
   endtask

   task automatic do_step(input logic [1:0] d, input bit g, input bit pulse);
      logic [7:0] h, nh;
      logic [3:0] nx, ny;
      bit         geff;
      int         start, n, hit, lat, k;
      if (dead) begin
         step = 1'b1;
         dir = d;
         grow = g;
         tick();
         step = 1'b0;
         repeat (3) tick();
         check("dead_busy", busy, 0);
         check("dead_plot", game_plot, 0);
         check("dead_collide", collide, 1);
         check("dead_len", len, body.size());
         return;
      end
      h = body[body.size() - 1];
      nx = h[7:4];
      ny = h[3:0];
      case (d)
         2'd0: nx = 4'((int'(h[7:4]) + 1) % 16);
         2'd1: ny = 4'((int'(h[3:0]) + 1) % 16);
         2'd2: nx = 4'((int'(h[7:4]) + 15) % 16);
         default: ny = 4'((int'(h[3:0]) + 15) % 16);
      endcase
      nh = {nx, ny};
      geff = g && (body.size() < MAXL);
      start = geff ? 0 : 1;
      n = body.size() - start;
      hit = 0;
      for (int i = 0; i < n; i++)
         if (hit == 0 && body[start + i] == nh) hit = i + 1;
      lat = (hit != 0) ? hit : ((n > 0) ? n : 1);
      step = 1'b1;
      dir = d;
      grow = g;
      tick();
      step = 1'b0;
      if (hit != 0) begin
         dead = 1'b1;
      end else begin
         if (!geff) begin
            exp_q.push_back({body[0], BG});
            void'(body.pop_front());
         end
         exp_q.push_back({nh, SNAKE});
         body.push_back(nh);
      end
      k = 0;
      while (!(game_plot || collide) && k < 100) begin
         tick();
         k++;
      end
      check("latency", k, lat);
      if (pulse && hit == 0) begin
         step = 1'b1;
         dir = ~d;
         grow = 1'b1;
         tick();
         step = 1'b0;
      end
      wait_idle();
      if (pulse && hit == 0) begin
         repeat (4) tick();
         check("no_queued_busy", busy, 0);
         check("no_queued_plot", game_plot, 0);
      end
   endtask

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int n;
      tick();
      do_reset(1'b1);
      do_step(2'd0, 1'b0, 1'b0);
      repeat (5) do_step(2'd3, 1'b0, 1'b0);
      repeat (7) do_step(2'd0, 1'b0, 1'b0);
      repeat (3) do_step(2'd3, 1'b0, 1'b0);
      do_step(2'd3, 1'b0, 1'b0);
      check("wrap_head", body[0], 8'h0f);

      do_reset(1'b0);
      do_step(2'd0, 1'b1, 1'b0);
      do_step(2'd0, 1'b1, 1'b0);
      do_step(2'd1, 1'b1, 1'b0);
      do_step(2'd1, 1'b1, 1'b0);
      check("len_five", len, 5);
      do_step(2'd2, 1'b0, 1'b0);
      do_step(2'd3, 1'b0, 1'b0);
      do_step(2'd0, 1'b0, 1'b0);
      check("loop_dead", collide, 1);
      do_step(2'd1, 1'b0, 1'b0);

      do_reset(1'b0);
      do_step(2'd0, 1'b1, 1'b0);
      do_step(2'd1, 1'b1, 1'b0);
      do_step(2'd2, 1'b1, 1'b0);
      repeat (2) begin
         do_step(2'd3, 1'b0, 1'b0);
         do_step(2'd0, 1'b0, 1'b0);
         do_step(2'd1, 1'b0, 1'b0);
         do_step(2'd2, 1'b0, 1'b0);
      end
      check("tail_chase_alive", collide, 0);
      do_step(2'd3, 1'b1, 1'b0);
      check("grow_onto_tail_dead", collide, 1);

      do_reset(1'b0);
      repeat (8) do_step(2'd0, 1'b1, 1'b0);
      check("len_full", len, MAXL);

      do_reset(1'b0);
      wr_hold = 36;
      do_step(2'd0, 1'b0, 1'b1);
      do_step(2'd1, 1'b1, 1'b1);
      do_step(2'd0, 1'b0, 1'b0);
      wr_hold = 0;
      wr_force = 1'b1;
      repeat (40) tick();
      step = 1'b1;
      dir = 2'd0;
      grow = 1'b0;
      tick();
      step = 1'b0;
      n = 0;
      while (!game_plot && n < 50) begin
         tick();
         n++;
      end
      check("erase_pending", {game_plot, game_colour}, {1'b1, BG});
      repeat (3) tick();
      do_reset(1'b0);

      wr_rand = 1'b1;
      do_reset(1'b0);
      for (int i = 0; i < 300; i++) begin
         if (dead && $urandom_range(0, 2) == 0)
            do_reset(1'b0);
         else
            do_step(2'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
